// File: rtl/start_line_controller.sv
// Reaction-game sequencer: picks a pseudo-random delay, arms the external delay block,
// lights the go lamp on completion, then times the player's press.
module start_line_controller #(
  parameter int unsigned DELAY_W   = 7,
  parameter int unsigned MIN_DELAY = 4,
  parameter int unsigned REACT_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_arst,
  input  logic               i_start,
  input  logic               i_button,
  input  logic               i_delayComplete,
  output logic [DELAY_W-1:0] o_delay,
  output logic               o_sampleAndStart,
  output logic               o_go,
  output logic               o_busy,
  output logic               o_done,
  output logic [REACT_W-1:0] o_reactTime,
  output logic               o_falseStart,
  output logic               o_timeout
);

  localparam logic [15:0]        LfsrSeed = 16'hACE1;
  localparam logic [DELAY_W-1:0] MinDelay = DELAY_W'(MIN_DELAY);

  typedef enum logic [2:0] {StIdle, StArm, StWait, StGo, StDone, StFault} state_e;

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [REACT_W-1:0] count_q, count_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic               sample_q, sample_d;
  logic               go_q, go_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [REACT_W-1:0] react_q, react_d;
  logic               false_q, false_d;
  logic               timeout_q, timeout_d;
  logic [DELAY_W-1:0] delay_pick;

  // Low LFSR bits, clamped so the delay block never sees a too-short delay.
  assign delay_pick = (lfsr_q[DELAY_W-1:0] < MinDelay) ? MinDelay : lfsr_q[DELAY_W-1:0];

  always_comb begin
    state_d   = state_q;
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    count_d   = count_q;
    delay_d   = delay_q;
    sample_d  = 1'b0;
    go_d      = go_q;
    busy_d    = busy_q;
    done_d    = done_q;
    react_d   = react_q;
    false_d   = false_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle, StDone, StFault: begin
        if (i_start) begin
          state_d   = StArm;
          delay_d   = delay_pick;
          sample_d  = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          false_d   = 1'b0;
          react_d   = '0;
        end
      end
      StArm: state_d = StWait;
      StWait: begin
        if (i_button) begin
          state_d = StFault;
          false_d = 1'b1;
          busy_d  = 1'b0;
        end else if (i_delayComplete) begin
          state_d = StGo;
          go_d    = 1'b1;
          count_d = '0;
        end
      end
      StGo: begin
        if (i_button) begin
          state_d = StDone;
          react_d = count_q;
          done_d  = 1'b1;
          go_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (&count_q) begin
          state_d   = StDone;
          react_d   = '1;
          timeout_d = 1'b1;
          go_d      = 1'b0;
          busy_d    = 1'b0;
        end else begin
          count_d = count_q + REACT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q   <= StIdle;
      lfsr_q    <= LfsrSeed;
      count_q   <= '0;
      delay_q   <= '0;
      sample_q  <= 1'b0;
      go_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      react_q   <= '0;
      false_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      count_q   <= count_d;
      delay_q   <= delay_d;
      sample_q  <= sample_d;
      go_q      <= go_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      react_q   <= react_d;
      false_q   <= false_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_delay          = delay_q;
  assign o_sampleAndStart = sample_q;
  assign o_go             = go_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;
  assign o_reactTime      = react_q;
  assign o_falseStart     = false_q;
  assign o_timeout        = timeout_q;

endmodule

// File: tb/tb_start_line_controller.sv
// Bench for start_line_controller: a behavioural delay block and LFSR prediction drive
// randomized rounds on a 16-bit and a 4-bit reaction-counter instance in lockstep.
module tb_start_line_controller;

  logic        i_clk = 1'b0;
  logic        i_arst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_button = 1'b0;
  logic        i_delayComplete;

  logic [6:0]  o_delay, o_delay4;
  logic        o_sampleAndStart, o_sampleAndStart4;
  logic        o_go, o_go4, o_busy, o_busy4, o_done, o_done4;
  logic [15:0] o_reactTime;
  logic [3:0]  o_reactTime4;
  logic        o_falseStart, o_falseStart4, o_timeout, o_timeout4;

  int checks = 0;
  int passes = 0;

  start_line_controller #(.DELAY_W(7), .MIN_DELAY(4), .REACT_W(16)) dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_start(i_start), .i_button(i_button),
    .i_delayComplete(i_delayComplete), .o_delay(o_delay), .o_sampleAndStart(o_sampleAndStart),
    .o_go(o_go), .o_busy(o_busy), .o_done(o_done), .o_reactTime(o_reactTime),
    .o_falseStart(o_falseStart), .o_timeout(o_timeout)
  );

  start_line_controller #(.DELAY_W(7), .MIN_DELAY(4), .REACT_W(4)) dut4 (
    .i_clk(i_clk), .i_arst(i_arst), .i_start(i_start), .i_button(i_button),
    .i_delayComplete(i_delayComplete), .o_delay(o_delay4), .o_sampleAndStart(o_sampleAndStart4),
    .o_go(o_go4), .o_busy(o_busy4), .o_done(o_done4), .o_reactTime(o_reactTime4),
    .o_falseStart(o_falseStart4), .o_timeout(o_timeout4)
  );

  always #5 i_clk = ~i_clk;

  // Delay block: counter restarts on the load pulse and completes every 128 cycles.
  logic [6:0] db_cnt, db_val;
  logic       db_armed;
  always @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      db_cnt <= '0; db_val <= '0; db_armed <= 1'b0;
    end else if (o_sampleAndStart) begin
      db_cnt <= '0; db_val <= o_delay; db_armed <= 1'b1;
    end else begin
      db_cnt <= db_cnt + 7'd1;
    end
  end
  assign i_delayComplete = db_armed && (db_cnt == db_val);

  int unsigned cyc;
  always @(posedge i_clk or posedge i_arst) begin
    if (i_arst) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  logic [15:0] m_lfsr = 16'hACE1;
  int unsigned m_cyc = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  // LFSR value the DUT will use at the coming edge: seed advanced once per post-reset edge.
  task automatic predict(output logic [6:0] raw, output logic [6:0] d);
    if (cyc < m_cyc) begin m_lfsr = 16'hACE1; m_cyc = 0; end
    while (m_cyc < cyc) begin m_lfsr = lfsr_next(m_lfsr); m_cyc++; end
    raw = m_lfsr[6:0];
    d   = (raw < 7'd4) ? 7'd4 : raw;
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic begin_round(output logic [6:0] d);
    logic [6:0] raw;
    predict(raw, d);
    i_start = 1'b1; tick(); i_start = 1'b0;
  endtask

  task automatic wait_go(output int n);
    n = 0;
    while (o_go !== 1'b1 && n < 400) begin tick(); n++; end
    if (o_go !== 1'b1) n = -1;
  endtask

  // Entered on the first GO cycle; press is sampled k cycles after o_go rose.
  task automatic test_press(input int k);
    logic [3:0] exp4;
    exp4 = (k > 15) ? 4'd15 : 4'(k);
    for (int j = 0; j < k; j++) begin
      if (j == 15) begin
        checks++;
        if (o_timeout4 !== 1'b0 || o_go4 !== 1'b1)
          $display("FAIL sat_cycle4: timeout=%b go=%b want 0 1", o_timeout4, o_go4);
        else passes++;
      end
      if (j == 16) begin
        checks++;
        if (o_timeout4 !== 1'b1 || o_reactTime4 !== 4'd15 || o_go4 !== 1'b0)
          $display("FAIL timeout4: to=%b rt=%0d go=%b want 1 15 0", o_timeout4, o_reactTime4, o_go4);
        else passes++;
      end
      tick();
    end
    checks++;
    if (o_go !== 1'b1) $display("FAIL go_before_press: go=%b want 1", o_go);
    else passes++;
    i_button = 1'b1; tick(); i_button = 1'b0;
    checks++;
    if ({o_done, o_go, o_busy, o_timeout} !== 4'b1000)
      $display("FAIL press_flags: done/go/busy/to=%b want 1000", {o_done, o_go, o_busy, o_timeout});
    else passes++;
    checks++;
    if (o_reactTime !== 16'(k)) $display("FAIL react_time: got %0d want %0d", o_reactTime, k);
    else passes++;
    checks++;
    if (o_reactTime4 !== exp4 || o_timeout4 !== (k > 15) || (k <= 15 && o_done4 !== 1'b1))
      $display("FAIL react4: rt=%0d to=%b done=%b want %0d %b k=%0d",
               o_reactTime4, o_timeout4, o_done4, exp4, (k > 15), k);
    else passes++;
  endtask

  task automatic test_reset();
    i_arst = 1'b1; i_start = 1'b0; i_button = 1'b0;
    repeat (2) tick();
    checks++;
    if ({o_delay, o_sampleAndStart, o_go, o_busy, o_done, o_reactTime, o_falseStart, o_timeout} !== '0)
      $display("FAIL reset_outputs: got %h want 0",
               {o_delay, o_sampleAndStart, o_go, o_busy, o_done, o_reactTime, o_falseStart, o_timeout});
    else passes++;
    checks++;
    if ({o_delay4, o_go4, o_busy4, o_done4, o_reactTime4, o_falseStart4, o_timeout4} !== '0)
      $display("FAIL reset_outputs4: got %h want 0",
               {o_delay4, o_go4, o_busy4, o_done4, o_reactTime4, o_falseStart4, o_timeout4});
    else passes++;
    i_arst = 1'b0;
  endtask

  // Called immediately after release, so the start lands in the first post-reset cycle.
  task automatic test_first_round();
    logic [6:0] d;
    int n;
    begin_round(d);
    checks++;
    if (o_delay !== 7'd97 || o_sampleAndStart !== 1'b1 || o_busy !== 1'b1)
      $display("FAIL first_arm: delay=%0d pulse=%b busy=%b want 97 1 1", o_delay, o_sampleAndStart, o_busy);
    else passes++;
    tick();
    checks++;
    if (o_sampleAndStart !== 1'b0 || o_busy !== 1'b1)
      $display("FAIL arm_pulse_len: pulse=%b busy=%b want 0 1", o_sampleAndStart, o_busy);
    else passes++;
    wait_go(n);
    n = n + 1;
    checks++;
    if (n !== 99) $display("FAIL first_go_latency: got %0d want 99", n);
    else passes++;
    test_press(25);
  endtask

  task automatic test_reaction();
    logic [6:0] d;
    int n, k, prev_k;
    prev_k = 25;
    for (int r = 0; r < 5; r++) begin
      repeat ($urandom_range(1, 8)) tick();
      checks++;
      if (o_done !== 1'b1 || o_reactTime !== 16'(prev_k) || o_sampleAndStart !== 1'b0)
        $display("FAIL hold: done=%b rt=%0d want 1 %0d", o_done, o_reactTime, prev_k);
      else passes++;
      k = (r == 0) ? 15 : (r == 1) ? 0 : int'($urandom_range(1, 40));
      begin_round(d);
      checks++;
      if (o_sampleAndStart !== 1'b1 || o_delay !== d || o_done !== 1'b0 || o_reactTime !== 16'd0 ||
          o_timeout4 !== 1'b0 || o_reactTime4 !== 4'd0)
        $display("FAIL restart: pulse=%b delay=%0d done=%b rt=%0d to4=%b want 1 %0d 0 0 0",
                 o_sampleAndStart, o_delay, o_done, o_reactTime, o_timeout4, d);
      else passes++;
      wait_go(n);
      checks++;
      if (n !== int'(d) + 2) $display("FAIL go_latency: got %0d want %0d", n, int'(d) + 2);
      else passes++;
      test_press(k);
      prev_k = k;
    end
  endtask

  task automatic test_clamp();
    logic [6:0] raw, d;
    int n, c;
    c = 0;
    predict(raw, d);
    while (raw >= 7'd4 && c < 5000) begin tick(); c++; predict(raw, d); end
    i_start = 1'b1; tick(); i_start = 1'b0;
    checks++;
    if (o_delay !== 7'd4) $display("FAIL clamp_delay: got %0d want 4 (raw %0d)", o_delay, raw);
    else passes++;
    wait_go(n);
    checks++;
    if (n !== 6) $display("FAIL clamp_go_latency: got %0d want 6", n);
    else passes++;
    test_press(3);
  endtask

  task automatic test_false_start();
    logic [6:0] d;
    int c, r;
    logic saw_go;
    begin_round(d);
    tick();
    c = 0;
    while (i_delayComplete !== 1'b1 && c < 300) begin tick(); c++; end
    checks++;
    if (o_go !== 1'b0 || c >= 300) $display("FAIL wait_state: go=%b waited=%0d want 0 <300", o_go, c);
    else passes++;
    i_button = 1'b1; tick(); i_button = 1'b0;
    checks++;
    if ({o_falseStart, o_go, o_busy, o_done, o_falseStart4} !== 5'b10001)
      $display("FAIL false_same_cycle: fs/go/busy/done/fs4=%b want 10001",
               {o_falseStart, o_go, o_busy, o_done, o_falseStart4});
    else passes++;
    saw_go = 1'b0;
    repeat (300) begin tick(); if (o_go !== 1'b0) saw_go = 1'b1; end
    checks++;
    if (saw_go !== 1'b0 || o_falseStart !== 1'b1)
      $display("FAIL fault_hold: saw_go=%b fs=%b want 0 1", saw_go, o_falseStart);
    else passes++;
    begin_round(d);
    checks++;
    if (o_falseStart !== 1'b0 || o_sampleAndStart !== 1'b1)
      $display("FAIL fault_restart: fs=%b pulse=%b want 0 1", o_falseStart, o_sampleAndStart);
    else passes++;
    r = int'($urandom_range(0, int'(d)));
    tick();
    repeat (r) tick();
    i_button = 1'b1; tick(); i_button = 1'b0;
    checks++;
    if (o_falseStart !== 1'b1 || o_go !== 1'b0)
      $display("FAIL false_early: fs=%b go=%b want 1 0 (r=%0d d=%0d)", o_falseStart, o_go, r, d);
    else passes++;
  endtask

  task automatic test_async_reset();
    logic [6:0] d;
    int n;
    begin_round(d);
    tick(); tick();
    i_start = 1'b1; tick(); i_start = 1'b0;
    n = 3;
    checks++;
    if (o_sampleAndStart !== 1'b0 || o_busy !== 1'b1 || o_go !== 1'b0)
      $display("FAIL start_in_wait: pulse=%b busy=%b go=%b want 0 1 0", o_sampleAndStart, o_busy, o_go);
    else passes++;
    while (o_go !== 1'b1 && n < 400) begin tick(); n++; end
    checks++;
    if (n !== int'(d) + 2) $display("FAIL wait_go_after_start: got %0d want %0d", n, int'(d) + 2);
    else passes++;
    repeat (3) tick();
    #2 i_arst = 1'b1;
    #1;
    checks++;
    if ({o_delay, o_sampleAndStart, o_go, o_busy, o_done, o_reactTime, o_falseStart, o_timeout,
         o_go4, o_busy4, o_delay4} !== '0)
      $display("FAIL async_reset: go=%b busy=%b delay=%0d want all 0", o_go, o_busy, o_delay);
    else passes++;
    tick();
    i_arst = 1'b0;
    i_start = 1'b1; tick(); i_start = 1'b0;
    checks++;
    if (o_delay !== 7'd97 || o_sampleAndStart !== 1'b1)
      $display("FAIL post_reset_arm: delay=%0d pulse=%b want 97 1", o_delay, o_sampleAndStart);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_reaction();
    test_clamp();
    test_false_start();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
